uart_rx: RTL and testbench

- Serial receiver that sits directly downstream of the UART transmitter.
- Samples the 8N1 line (idle high, start 0, 8 data bits LSB first, stop 1) at the same CLKS_PER_BIT rate as the transmitter and recovers each byte.
- Presents each frame as a one-cycle rx_valid pulse with rx_data and error qualifiers.
- Feeds the byte-consuming logic, and the transmitter in loopback.

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling; optional even parity via UART_RX_PARITY_EN
module uart_rx #(
    parameter int CLKS_PER_BIT = 521
) (
    input  logic       rx_clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK_WAIT
    } state_t;

    state_t      state, next_state;
    logic        sync1, rx_s;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        timed;
    logic        bit_end;
    logic        stop_sample;

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        timed       = 1'b0;
        bit_end     = 1'b0;
        stop_sample = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) next_state = START;
            end
            START: begin
                timed = 1'b1;
                // Mid-point re-check rejects short glitches on the line
                if (cnt == HALF_BIT) next_state = rx_s ? IDLE : DATA;
            end
            DATA: begin
                timed   = 1'b1;
                bit_end = (cnt == BIT_LAST);
                if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                timed   = 1'b1;
                bit_end = (cnt == BIT_LAST);
                if (bit_end) next_state = STOP;
            end
`endif
            STOP: begin
                timed       = 1'b1;
                bit_end     = (cnt == BIT_LAST);
                stop_sample = bit_end;
                // Leaving at mid-stop lets a start edge follow with no idle gap
                if (bit_end) next_state = rx_s ? IDLE : BREAK_WAIT;
            end
            BREAK_WAIT: begin
                if (rx_s) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 16'd0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (state != next_state || bit_end) begin
                cnt <= 16'd0;
            end else if (timed) begin
                cnt <= cnt + 16'd1;
            end
            if (state == DATA && bit_end) begin
                shift[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 3'd1;
            end
            if (stop_sample) begin
                rx_valid  <= 1'b1;
                rx_data   <= shift;
                frame_err <= ~rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bit;
    logic parity_q;

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_bit <= 1'b0;
            parity_q   <= 1'b0;
        end else begin
            parity_q <= 1'b0;
            if (state == PARITY && bit_end) parity_bit <= rx_s;
            if (stop_sample) parity_q <= parity_bit ^ (^shift);
        end
    end

    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized bench for uart_rx against a line-timeline reference model
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB        = 9;
    localparam int VALID_LAT = 170;
    localparam int FRAME_CYC = 176;
`else
    localparam int NB        = 8;
    localparam int VALID_LAT = 154;
    localparam int FRAME_CYC = 160;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int te_last;

    int         vcyc[$];
    logic [7:0] vdat[$];
    logic       vfe[$];
    logic       vpe[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .rx_clk    (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: decisions at edge c depend on the line value captured at edge c-2;
    // frame events are placed on absolute edges measured from the start capture edge.
    int         mode_m = 0;  // 0 hunting, 1 in frame, 2 waiting for line high
    int         te_m   = 0;
    logic       h1 = 1'b1, h2 = 1'b1;
    logic [7:0] dbits  = 8'h00;
    logic       pbit   = 1'b0;
    logic       exp_valid = 1'b0, exp_ferr = 1'b0, exp_perr = 1'b0, exp_busy = 1'b0;
    logic [7:0] exp_data = 8'h00;

    task automatic model_reset();
        mode_m = 0; h1 = 1'b1; h2 = 1'b1;
        exp_valid = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0; exp_busy = 1'b0;
        exp_data = 8'h00;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        int   b, k;
        logic s;
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            s  = h2;
            h2 = h1;
            h1 = rx_in;
            exp_valid = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0;
            case (mode_m)
                0: if (!s) begin te_m = cyc - 2; mode_m = 1; exp_busy = 1'b1; end
                1: begin
                    b = cyc - (te_m + 3 + HALF);
                    if (b == 0) begin
                        if (s) begin mode_m = 0; exp_busy = 1'b0; end
                    end else if (b > 0 && b % CPB == 0) begin
                        k = b / CPB;
                        if (k <= 8) dbits[k-1] = s;
                        else if (k <= NB) pbit = s;
                        else begin
                            exp_valid = 1'b1;
                            exp_data  = dbits;
                            exp_ferr  = !s;
                            exp_perr  = (NB == 9) ? (pbit ^ (^dbits)) : 1'b0;
                            mode_m    = s ? 0 : 2;
                            exp_busy  = !s;
                        end
                    end
                end
                default: if (s) begin mode_m = 0; exp_busy = 1'b0; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            vcyc.push_back(cyc); vdat.push_back(rx_data);
            vfe.push_back(frame_err); vpe.push_back(parity_err);
        end
        chk("rx_valid", rx_valid, exp_valid);
        chk("rx_data", rx_data, exp_data);
        chk("frame_err", frame_err, exp_ferr);
        chk("parity_err", parity_err, exp_perr);
        chk("rx_busy", rx_busy, exp_busy);
    end

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            rx_in = v;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
        te_last = cyc + 1;
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive(par_v, CPB);
`endif
        drive(stop_v, CPB);
    endtask

    initial begin
        int n0, te0;
        logic [7:0] d;
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset rx_data", rx_data, 8'h00);
        chk("reset rx_valid", rx_valid, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset rx_busy", rx_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 10);

        // Ideal frame: latency pinned by hand
        n0 = vcyc.size();
        send_frame(8'hA5, 1'b1, 1'b0);
        drive(1'b1, 20);
        #1;
        chk("t1 count", vcyc.size() - n0, 1);
        if (vcyc.size() > n0) begin
            chk("t1 cycle", vcyc[n0] - te_last, VALID_LAT);
            chk("t1 data", vdat[n0], 8'hA5);
            chk("t1 ferr", vfe[n0], 1'b0);
        end
        chk("t1 busy", rx_busy, 1'b0);

        // Glitch rejection
        n0 = vcyc.size();
        drive(1'b0, 5);
        drive(1'b1, 200);
        chk("t2 count", vcyc.size() - n0, 0);

        // Stop bit low followed by a held-low line
        n0 = vcyc.size();
        send_frame(8'h3C, 1'b0, 1'b0);
        drive(1'b0, 40);
        #1;
        chk("t3 busy held", rx_busy, 1'b1);
        drive(1'b1, 40);
        #1;
        chk("t3 count", vcyc.size() - n0, 1);
        if (vcyc.size() > n0) begin
            chk("t3 data", vdat[n0], 8'h3C);
            chk("t3 ferr", vfe[n0], 1'b1);
        end
        chk("t3 busy", rx_busy, 1'b0);

        // Back-to-back frames, no idle
        n0 = vcyc.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        drive(1'b1, 20);
        chk("t4 count", vcyc.size() - n0, 3);
        if (vcyc.size() >= n0 + 3) begin
            chk("t4 gap1", vcyc[n0+1] - vcyc[n0], FRAME_CYC);
            chk("t4 gap2", vcyc[n0+2] - vcyc[n0+1], FRAME_CYC);
            chk("t4 d0", vdat[n0], 8'h00);
            chk("t4 d1", vdat[n0+1], 8'hFF);
            chk("t4 d2", vdat[n0+2], 8'h55);
        end

        // Reset in the middle of data bit 4 of 0x81
        n0 = vcyc.size();
        drive(1'b0, CPB);
        drive(1'b1, CPB);
        drive(1'b0, 3 * CPB);
        drive(1'b0, CPB / 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 rst data", rx_data, 8'h00);
        chk("t5 rst busy", rx_busy, 1'b0);
        chk("t5 rst valid", rx_valid, 1'b0);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 20);
        send_frame(8'h42, 1'b1, 1'b1);
        drive(1'b1, 20);
        chk("t5 count", vcyc.size() - n0, 1);
        if (vcyc.size() > n0) chk("t5 data", vdat[n0], 8'h42);

`ifdef UART_RX_PARITY_EN
        n0 = vcyc.size();
        send_frame(8'h07, 1'b1, 1'b1);
        drive(1'b1, 10);
        te0 = te_last;
        send_frame(8'h07, 1'b1, 1'b0);
        drive(1'b1, 10);
        chk("t6 count", vcyc.size() - n0, 2);
        if (vcyc.size() >= n0 + 2) begin
            chk("t6 perr good", vpe[n0], 1'b0);
            chk("t6 perr bad", vpe[n0+1], 1'b1);
            chk("t6 cycle", vcyc[n0] - te0, 170);
        end
`endif

        // Randomized traffic, checked cycle by cycle against the model
        for (int f = 0; f < 40; f++) begin
            d = 8'($urandom);
            case ($urandom_range(0, 7))
                0: begin
                    drive(1'b0, $urandom_range(1, 12));
                    drive(1'b1, $urandom_range(1, 30));
                end
                1: begin
                    send_frame(d, 1'b0, ^d);
                    drive(1'b0, $urandom_range(0, 40));
                    drive(1'b1, $urandom_range(1, 20));
                end
                default: begin
                    send_frame(d, 1'b1, ($urandom_range(0, 3) == 0) ? ~(^d) : ^d);
                    drive(1'b1, $urandom_range(0, 20));
                end
            endcase
        end
        drive(1'b1, 400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
